frame_stuffer: RTL and testbench

- Transmit-side framer for the serial link.
- Takes one complete parallel frame (preamble + data + CRC + optional nonce) from the core and emits it as a byte stream to the UART transmitter.
- Stream form: FRAME_START flag, byte-stuffed body, FRAME_END flag.
- It is the exact inverse of the receive deframer: any byte equal to a flag or the escape value is sent as ESC_VAL followed by (byte XOR ESC_XOR).

---
 rtl/frame_stuffer.sv | 123 ++++++++++++
 tb/tb_frame_stuffer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stuffer.sv
// Transmit framer: one parallel frame in, FRAME_START + byte-stuffed body + FRAME_END out.
// Latency: first byte (FRAME_START) on tx_data the cycle after fin is accepted, one byte per transfer.
// Backpressure: tx_data/tx_valid hold while tx_ready is low; fin_ready stays low until FRAME_END is taken.
module frame_stuffer #(
    parameter int          DATA_SIZE     = 64,
    parameter int          PREAMBLE_SIZE = 7,
    parameter int          CRC_SIZE      = 4,
    parameter int          NONCE_SIZE    = 12,
    parameter logic [7:0]  FRAME_START   = 8'h06,
    parameter logic [7:0]  FRAME_END     = 8'h07,
    parameter logic [7:0]  ESC_VAL       = 8'h14,
    parameter logic [7:0]  ESC_XOR       = 8'h20,
    localparam int         FRAME_BYTES   = PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE + NONCE_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [0:FRAME_BYTES*8-1]   fin,
    input  logic                       fin_valid,
    output logic                       fin_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       semafor_out,
    output logic                       done
);

    localparam int              IDX_W    = $clog2(FRAME_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        BODY,
        ESC2,
        END_FLAG
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [0:FRAME_BYTES*8-1]  frame_q;

    logic [7:0] cur_byte;
    logic [7:0] next_byte;
    logic       xfer;
    logic       last_byte;

    function automatic logic is_special(input logic [7:0] b);
        return (b == FRAME_START) || (b == FRAME_END) || (b == ESC_VAL);
    endfunction

    function automatic logic [7:0] first_out(input logic [7:0] b);
        return is_special(b) ? ESC_VAL : b;
    endfunction

    // The frame register shifts one byte per advance, so the byte being sent is always the head.
    assign cur_byte  = frame_q[0:7];
    assign next_byte = frame_q[8:15];
    assign xfer      = tx_valid && tx_ready;
    assign last_byte = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            frame_q     <= '0;
            fin_ready   <= 1'b1;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            semafor_out <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fin_valid && fin_ready) begin
                        frame_q     <= fin;
                        idx         <= '0;
                        fin_ready   <= 1'b0;
                        semafor_out <= 1'b1;
                        tx_data     <= FRAME_START;
                        tx_valid    <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    if (xfer) begin
                        tx_data <= first_out(cur_byte);
                        state   <= BODY;
                    end
                end
                BODY, ESC2: begin
                    if (xfer) begin
                        if (state == BODY && is_special(cur_byte)) begin
                            tx_data <= cur_byte ^ ESC_XOR;
                            state   <= ESC2;
                        end else if (last_byte) begin
                            tx_data <= FRAME_END;
                            state   <= END_FLAG;
                        end else begin
                            idx     <= idx + 1'b1;
                            frame_q <= frame_q << 8;
                            tx_data <= first_out(next_byte);
                            state   <= BODY;
                        end
                    end
                end
                END_FLAG: begin
                    if (xfer) begin
                        tx_valid    <= 1'b0;
                        done        <= 1'b1;
                        semafor_out <= 1'b0;
                        fin_ready   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_stuffer.sv
// Directed bench for frame_stuffer with a 75-byte frame (no nonce).
module tb_frame_stuffer;

    localparam int FB = 75;

    logic            clk = 1'b0;
    logic            rst;
    logic [0:FB*8-1] fin;
    logic            fin_valid;
    logic            fin_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            semafor_out;
    logic            done;

    always #5 clk = ~clk;

    frame_stuffer #(.NONCE_SIZE(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .fin         (fin),
        .fin_valid   (fin_valid),
        .fin_ready   (fin_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .semafor_out (semafor_out),
        .done        (done)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] fbytes [FB];
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    int         done_cnt = 0;
    int         sem_bad = 0;
    int         stall_bad = 0;
    int         stall_events = 0;
    logic       stall_mode = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] held = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // tx_ready changes just after posedge; in stall mode it drops for runs of 5 cycles.
    initial begin
        int stall_left;
        stall_left = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_mode) begin
                tx_ready = 1'b1;
                stall_left = 0;
            end else if (stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 3) == 0) begin
                tx_ready = 1'b0;
                stall_left = 4;
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (stall_prev && (!tx_valid || tx_data !== held))
            stall_bad++;
        stall_prev = tx_valid && !tx_ready;
        held = tx_data;
        if (stall_prev)
            stall_events++;
        if (tx_valid && tx_ready)
            rx_q.push_back(tx_data);
        if (tx_valid && !semafor_out)
            sem_bad++;
        if (done)
            done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int k = 0; k < FB; k++) fbytes[k] = v;
    endtask

    task automatic load_fin();
        for (int k = 0; k < FB; k++) fin[8*k +: 8] = fbytes[k];
    endtask

    task automatic build_exp();
        exp_q.delete();
        exp_q.push_back(8'h06);
        for (int k = 0; k < FB; k++) begin
            if (fbytes[k] == 8'h06 || fbytes[k] == 8'h07 || fbytes[k] == 8'h14) begin
                exp_q.push_back(8'h14);
                exp_q.push_back(fbytes[k] ^ 8'h20);
            end else begin
                exp_q.push_back(fbytes[k]);
            end
        end
        exp_q.push_back(8'h07);
    endtask

    task automatic send_frame(input string tag);
        chk({tag, "_ready_before"}, fin_ready, 1'b1);
        rx_q.delete();
        done_cnt = 0;
        sem_bad = 0;
        load_fin();
        fin_valid = 1'b1;
        tick();
        fin_valid = 1'b0;
        chk({tag, "_first_vld"}, tx_valid, 1'b1);
        chk({tag, "_first_dat"}, tx_data, 8'h06);
        chk({tag, "_busy_ready"}, fin_ready, 1'b0);
        chk({tag, "_semafor_on"}, semafor_out, 1'b1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, done, 1'b1);
    endtask

    task automatic wait_rx(input string tag, input int cnt, input int budget);
        int n;
        n = 0;
        while (rx_q.size() < cnt && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_rx_reached"}, rx_q.size(), cnt);
    endtask

    task automatic end_checks(input string tag);
        chk({tag, "_end_semafor"}, semafor_out, 1'b0);
        chk({tag, "_end_ready"}, fin_ready, 1'b1);
        chk({tag, "_end_vld"}, tx_valid, 1'b0);
        tick();
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_semafor_span"}, sem_bad, 0);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        chk({tag, "_len"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
    endtask

    // Hand-written stream for: byte0=06, byte1=14, byte74=07, rest 00.
    task automatic hand_exp_escapes();
        exp_q.delete();
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h14); exp_q.push_back(8'h26);
        exp_q.push_back(8'h14); exp_q.push_back(8'h34);
        for (int i = 0; i < 72; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'h14); exp_q.push_back(8'h27);
        exp_q.push_back(8'h07);
    endtask

    task automatic esc_frame();
        fill(8'h00);
        fbytes[0]  = 8'h06;
        fbytes[1]  = 8'h14;
        fbytes[74] = 8'h07;
    endtask

    // Hand-written stream for: byte10=20, byte11=26, rest 11.
    task automatic hand_exp_plain();
        exp_q.delete();
        exp_q.push_back(8'h06);
        for (int i = 0; i < 10; i++) exp_q.push_back(8'h11);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h26);
        for (int i = 0; i < 63; i++) exp_q.push_back(8'h11);
        exp_q.push_back(8'h07);
    endtask

    task automatic plain_frame();
        fill(8'h11);
        fbytes[10] = 8'h20;
        fbytes[11] = 8'h26;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        fin_valid = 1'b0;
        fin = '0;
        repeat (3) tick();
        chk("rst_fin_ready", fin_ready, 1'b1);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_semafor", semafor_out, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle_tx_valid", tx_valid, 1'b0);

        // Uniform body, tx_ready tied high.
        fill(8'hA5);
        send_frame("a5");
        wait_done("a5", 300);
        end_checks("a5");
        build_exp();
        compare_stream("a5");
        chk("a5_len_hand", rx_q.size(), 77);

        // Flag and escape values in the body.
        esc_frame();
        send_frame("esc");
        wait_done("esc", 300);
        end_checks("esc");
        hand_exp_escapes();
        compare_stream("esc");
        chk("esc_len_hand", rx_q.size(), 80);

        // ESC_XOR value and an already-xored value pass through untouched.
        plain_frame();
        send_frame("plain");
        wait_done("plain", 300);
        end_checks("plain");
        hand_exp_plain();
        compare_stream("plain");

        // Same escape frame under 5-cycle stalls.
        stall_mode = 1'b1;
        stall_bad = 0;
        stall_events = 0;
        esc_frame();
        send_frame("stall");
        wait_done("stall", 3000);
        stall_mode = 1'b0;
        end_checks("stall");
        hand_exp_escapes();
        compare_stream("stall");
        chk("stall_hold", stall_bad, 0);
        chk("stall_seen", stall_events > 0, 1'b1);
        repeat (2) tick();

        // Frame offered while busy is ignored; a held offer is taken as fin_ready rises.
        fill(8'hA5);
        send_frame("busy");
        wait_rx("busy", 20, 100);
        fill(8'h06);
        load_fin();
        fin_valid = 1'b1;
        tick();
        fin_valid = 1'b0;
        chk("busy_ignored_ready", fin_ready, 1'b0);
        fill(8'h33);
        load_fin();
        fin_valid = 1'b1;
        wait_done("busy", 300);
        chk("busy_end_ready", fin_ready, 1'b1);
        fill(8'hA5);
        build_exp();
        compare_stream("busy");
        rx_q.delete();
        done_cnt = 0;
        tick();
        fin_valid = 1'b0;
        chk("b2b_first_vld", tx_valid, 1'b1);
        chk("b2b_first_dat", tx_data, 8'h06);
        chk("b2b_busy_ready", fin_ready, 1'b0);
        wait_done("b2b", 300);
        end_checks("b2b");
        fill(8'h33);
        build_exp();
        compare_stream("b2b");

        // Reset in the middle of a frame, then a clean frame.
        fill(8'hA5);
        send_frame("abort");
        wait_rx("abort", 10, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_tx_valid", tx_valid, 1'b0);
        chk("abort_fin_ready", fin_ready, 1'b1);
        chk("abort_semafor", semafor_out, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_tx_data", tx_data, 8'h00);
        tick();
        plain_frame();
        send_frame("after");
        wait_done("after", 300);
        end_checks("after");
        hand_exp_plain();
        compare_stream("after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
